sram_1rw_req_adapter: RTL and testbench

SRAM_1RW_REQ_ADAPTER -- requirements
Module: sram_1rw_req_adapter

---
 rtl/sram_1rw_req_adapter.sv | 167 ++++++++++++++++
 tb/tb_sram_1rw_req_adapter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_req_adapter.sv
// sram_1rw_req_adapter
// Bridges a valid/ready request stream onto a single-port synchronous SRAM
// macro with one cycle of read latency. Read data is captured into a small
// in-order response FIFO. The request side is credit-limited so that every
// read that is accepted always has a FIFO slot waiting for it.
//
// Handshake semantics:
//   request : a transfer happens in any cycle where v_i & ready_o. ready_o is
//             a function of registered state and reset_i only. It never
//             depends on v_i, w_i or yumi_i. A requester may raise v_i
//             without waiting for ready_o and must hold the request until it
//             is accepted.
//   response: v_o/data_o come from registers. The consumer pulses yumi_i in
//             a cycle where v_o=1 to pop the head entry. yumi_i with v_o=0 is
//             illegal.
module sram_1rw_req_adapter #(
  parameter int width_p      = 64,
  parameter int els_p        = 512,
  parameter int addr_width_p = 9,
  parameter int fifo_els_p   = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_i,

  input  logic                    v_i,
  input  logic                    w_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [width_p-1:0]      data_i,
  input  logic [width_p-1:0]      w_mask_i,
  output logic                    ready_o,

  output logic                    v_o,
  output logic [width_p-1:0]      data_o,
  input  logic                    yumi_i,

  output logic                    sram_ce_o,
  output logic                    sram_we_o,
  output logic [addr_width_p-1:0] sram_addr_o,
  output logic [width_p-1:0]      sram_wd_o,
  output logic [width_p-1:0]      sram_w_mask_o,
  input  logic [width_p-1:0]      sram_rd_i
);

  // Counters span 0..fifo_els_p inclusive. Pointers span 0..fifo_els_p-1.
  localparam int CNT_W = $clog2(fifo_els_p + 1);
  localparam int PTR_W = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(fifo_els_p);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(fifo_els_p - 1);

  // Request-side decode.
  logic fire;
  logic rd_fire;

  // Response FIFO events.
  logic enq;
  logic deq;

  // Registered state and next-state.
  logic               inflight_q;
  logic               inflight_d;
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   wptr_d;
  logic [PTR_W-1:0]   rptr_q;
  logic [PTR_W-1:0]   rptr_d;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   pending_q;
  logic [CNT_W-1:0]   pending_d;

  logic [width_p-1:0] mem_q [fifo_els_p];

  // pending counts FIFO entries plus the read still in the SRAM pipeline.
  // Holding it below the FIFO depth guarantees that each capture has room.
  assign ready_o = ~reset_i & (pending_q < FULL_CNT);

  // fire is gated by ready_o, which is low in reset. So ce/we stay 0 in
  // reset and in idle cycles even if w_i is unknown.
  assign fire    = v_i & ready_o;
  assign rd_fire = fire & ~w_i;

  assign sram_ce_o     = fire;
  assign sram_we_o     = fire & w_i;
  assign sram_addr_o   = addr_i;
  assign sram_wd_o     = data_i;
  assign sram_w_mask_o = w_mask_i;

  // sram_rd_i is sampled only in the one cycle after a read fire. In every
  // other cycle the macro output is undefined.
  assign enq = inflight_q & ~reset_i;
  assign deq = yumi_i & v_o;

  // The head entry sits in a register, so the response outputs are registered.
  assign v_o    = (count_q != '0);
  assign data_o = mem_q[rptr_q];

  // Next-state for the read pipeline flag, FIFO pointers, occupancy and pending.
  always_comb begin
    inflight_d = rd_fire;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    pending_d  = pending_q;

    if (enq) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (deq) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end

    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    unique case ({rd_fire, deq})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
  end

  // Control state update. A reset drops any read in flight.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      pending_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
    end
  end

  // Response storage. The data path is not reset and is written only on capture.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_q[wptr_q] <= sram_rd_i;
    end
  end

  // Simulation-only protocol and consistency checks.
  a_yumi_needs_valid : assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
  );

  a_pending_consistent : assert property (
    @(posedge clk_i) disable iff (reset_i)
      pending_q == (count_q + CNT_W'(inflight_q))
  );

  a_pending_bounded : assert property (
    @(posedge clk_i) disable iff (reset_i) pending_q <= FULL_CNT
  );

  a_addr_in_range : assert property (
    @(posedge clk_i) disable iff (reset_i) fire |-> (int'(addr_i) < els_p)
  );

endmodule

// File: tb/tb_sram_1rw_req_adapter.sv
// Directed bench for sram_1rw_req_adapter. A behavioural SRAM macro drives
// sram_rd_i. Expected response values are written as constants next to each
// check.
module tb_sram_1rw_req_adapter;

  localparam int W  = 64;
  localparam int AW = 9;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          reset_i;
  logic          v_i;
  logic          w_i;
  logic [AW-1:0] addr_i;
  logic [W-1:0]  data_i;
  logic [W-1:0]  w_mask_i;
  logic          ready_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;
  logic          sram_ce_o;
  logic          sram_we_o;
  logic [AW-1:0] sram_addr_o;
  logic [W-1:0]  sram_wd_o;
  logic [W-1:0]  sram_w_mask_o;
  logic [W-1:0]  sram_rd_i;

  sram_1rw_req_adapter #(
    .width_p(W), .els_p(512), .addr_width_p(AW), .fifo_els_p(3)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .v_i(v_i), .w_i(w_i), .addr_i(addr_i), .data_i(data_i),
    .w_mask_i(w_mask_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_wd_o(sram_wd_o), .sram_w_mask_o(sram_w_mask_o),
    .sram_rd_i(sram_rd_i)
  );

  // ---------------- SRAM macro model ----------------
  // The read port shows random data after any cycle with ce low.
  logic [W-1:0] sram_mem [512];
  always @(posedge clk_i) begin
    if (sram_ce_o) begin
      if (sram_we_o) begin
        sram_mem[sram_addr_o] <= (sram_mem[sram_addr_o] & ~sram_w_mask_o) |
                                 (sram_wd_o & sram_w_mask_o);
        sram_rd_i <= {$urandom, $urandom};
      end else begin
        sram_rd_i <= sram_mem[sram_addr_o];
      end
    end else begin
      sram_rd_i <= {$urandom, $urandom};
    end
  end

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // After tick the bench is 1 time unit past the rising edge. It drives
  // inputs there and checks 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_word(input int a, input logic [W-1:0] d,
                            input logic [W-1:0] m);
    v_i      = 1'b1;
    w_i      = 1'b1;
    addr_i   = AW'(a);
    data_i   = d;
    w_mask_i = m;
    #1;
    check("wr_ready", ready_o, 1);
    check("wr_we", sram_we_o, 1);
    tick();
    v_i = 1'b0;
    w_i = 1'b0;
  endtask

  // Time-limited run: an expired limit is reported as a failure.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i  = 1'b1;
    v_i      = 1'b1;
    w_i      = 1'b1;
    addr_i   = '0;
    data_i   = '0;
    w_mask_i = '0;
    yumi_i   = 1'b0;

    // Reset: hold with a live request present. The SRAM controls must stay low.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rst_ready", ready_o, 0);
      check("rst_v_o", v_o, 0);
      check("rst_ce", sram_ce_o, 0);
      check("rst_we", sram_we_o, 0);
    end
    reset_i = 1'b0;
    v_i     = 1'b0;
    w_i     = 1'b0;
    #1;
    check("post_rst_ready", ready_o, 1);
    check("post_rst_v_o", v_o, 0);
    tick();

    // Masked write merge, then a read. The response appears 2 cycles after fire.
    write_word(5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    write_word(5, 64'h0, 64'h0000_0000_FFFF_FFFF);
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd5;
    #1;
    check("rd5_ce", sram_ce_o, 1);
    check("rd5_we", sram_we_o, 0);
    tick();
    v_i = 1'b0;
    #1;
    check("rd5_lat1_v_o", v_o, 0);
    tick();
    #1;
    check("rd5_lat2_v_o", v_o, 1);
    check("rd5_data", data_o, 64'hFFFF_FFFF_0000_0000);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    #1;
    check("rd5_drained", v_o, 0);

    // Preload addr k with value k.
    for (int k = 0; k < 8; k++) write_word(k, W'(k), '1);

    // Back-to-back reads 0..7. The consumer pops whenever a response is valid.
    for (int c = 0; c < 10; c++) begin
      v_i    = (c < 8);
      w_i    = 1'b0;
      addr_i = AW'(c);
      yumi_i = v_o;
      #1;
      if (c < 8) check("b2b_ready", ready_o, 1);
      if (c >= 2) begin
        check("b2b_v_o", v_o, 1);
        check("b2b_data", data_o, W'(c - 2));
      end
      tick();
    end
    v_i = 1'b0; yumi_i = 1'b0;
    #1;
    check("b2b_drained", v_o, 0);
    tick();

    // Three reads with no consumer: credits run out and further requests stall.
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd1;
    tick();
    addr_i = 9'd2;
    tick();
    addr_i = 9'd3;
    #1;
    check("bp_ready_before_full", ready_o, 1);
    tick();
    w_i = 1'bx; addr_i = 9'd4;
    #1;
    check("bp_ready_full", ready_o, 0);
    check("bp_ce_full", sram_ce_o, 0);
    check("bp_we_full", sram_we_o, 0);
    tick();
    #1;
    check("bp_ce_hold", sram_ce_o, 0);
    check("bp_we_hold", sram_we_o, 0);
    check("bp_v_o", v_o, 1);
    check("bp_head1", data_o, 64'd1);
    tick();
    v_i = 1'b0; w_i = 1'b0; yumi_i = 1'b1;
    #1;
    check("bp_ready_still_full", ready_o, 0);
    check("bp_head1_stable", data_o, 64'd1);
    tick();
    #1;
    check("bp_ready_after_pop", ready_o, 1);
    check("bp_head2", data_o, 64'd2);
    tick();
    #1;
    check("bp_head3", data_o, 64'd3);
    check("bp_v_o3", v_o, 1);
    tick();
    yumi_i = 1'b0;
    #1;
    check("bp_drained", v_o, 0);

    // Read fire, capture and pop all land in one cycle with occupancy 1.
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd6;
    tick();
    addr_i = 9'd7;
    tick();
    addr_i = 9'd3; yumi_i = 1'b1;
    #1;
    check("cc_v_o", v_o, 1);
    check("cc_head6", data_o, 64'd6);
    check("cc_ready", ready_o, 1);
    tick();
    v_i = 1'b0;
    #1;
    check("cc_v_o_kept", v_o, 1);
    check("cc_head7", data_o, 64'd7);
    tick();
    #1;
    check("cc_head3", data_o, 64'd3);
    check("cc_ready_after", ready_o, 1);
    tick();
    yumi_i = 1'b0;
    #1;
    check("cc_drained", v_o, 0);

    // Reset lands while a read is in flight. That response must never appear.
    v_i = 1'b1; w_i = 1'b0; addr_i = 9'd2;
    tick();
    reset_i = 1'b1; w_i = 1'bx;
    #1;
    check("rf_ce", sram_ce_o, 0);
    check("rf_we", sram_we_o, 0);
    check("rf_ready", ready_o, 0);
    tick();
    reset_i = 1'b0; v_i = 1'b0; w_i = 1'b0;
    #1;
    check("rf_ready_after", ready_o, 1);
    check("rf_v_o_0", v_o, 0);
    tick();
    #1;
    check("rf_v_o_1", v_o, 0);
    tick();
    #1;
    check("rf_v_o_2", v_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
